// File: rtl/key_debouncer.sv
// Push-button conditioner: debounces a synchronized key and produces a held level,
// press/release strobes and a delayed-auto-shift repeat event stream.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned DAS_DELAY       = 10_000_000,
   parameter int unsigned DAS_PERIOD      = 2_500_000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter bit          PRESSED_LEVEL   = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic key_sync,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic key_event
);

   localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned T_MAX  = (DAS_DELAY > DAS_PERIOD) ? DAS_DELAY : DAS_PERIOD;
   localparam int unsigned TCNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TCNT_W-1:0] DELAY_LAST  = TCNT_W'(DAS_DELAY - 1);
   localparam logic [TCNT_W-1:0] PERIOD_LAST = TCNT_W'(DAS_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_RELEASED    = 2'd0,
      ST_HOLD_DELAY  = 2'd1,
      ST_HOLD_REPEAT = 2'd2
   } state_t;

   state_t            r_state;
   logic [DCNT_W-1:0] r_dcnt;
   logic [TCNT_W-1:0] r_tcnt;
   logic              r_level;
   logic              r_press;
   logic              r_release;
   logic              r_event;

   logic w_raw;
   logic w_disagree;
   logic w_accept;
   logic w_acc_press;
   logic w_acc_release;

   assign w_raw         = (key_sync == PRESSED_LEVEL);
   assign w_disagree    = (w_raw != r_level);
   assign w_accept      = w_disagree && (r_dcnt == DCNT_LAST);
   assign w_acc_press   = w_accept && w_raw;
   assign w_acc_release = w_accept && !w_raw;

   // Stability counter: any agreeing sample restarts the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_dcnt  <= '0;
         r_level <= 1'b0;
      end else if (!w_disagree) begin
         r_dcnt  <= '0;
      end else if (w_accept) begin
         r_dcnt  <= '0;
         r_level <= w_raw;
      end else begin
         r_dcnt  <= r_dcnt + DCNT_W'(1);
      end
   end

   // Repeat FSM; a release wins over a repeat terminal count on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_RELEASED;
         r_tcnt    <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_event   <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_event   <= 1'b0;
         case (r_state)
            ST_RELEASED: begin
               if (w_acc_press) begin
                  r_state <= ST_HOLD_DELAY;
                  r_tcnt  <= '0;
                  r_press <= 1'b1;
                  r_event <= 1'b1;
               end
            end
            ST_HOLD_DELAY: begin
               if (w_acc_release) begin
                  r_state   <= ST_RELEASED;
                  r_tcnt    <= '0;
                  r_release <= 1'b1;
               end else if (r_tcnt == DELAY_LAST) begin
                  r_state <= ST_HOLD_REPEAT;
                  r_tcnt  <= '0;
                  r_event <= REPEAT_EN;
               end else begin
                  r_tcnt  <= r_tcnt + TCNT_W'(1);
               end
            end
            ST_HOLD_REPEAT: begin
               if (w_acc_release) begin
                  r_state   <= ST_RELEASED;
                  r_tcnt    <= '0;
                  r_release <= 1'b1;
               end else if (r_tcnt == PERIOD_LAST) begin
                  r_tcnt  <= '0;
                  r_event <= REPEAT_EN;
               end else begin
                  r_tcnt  <= r_tcnt + TCNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_RELEASED;
               r_tcnt  <= '0;
            end
         endcase
      end
   end

   assign key_level     = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign key_event     = r_event;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random key bouncing, checked each
// cycle against a window/elapsed-time reference model, with and without auto-repeat.
module tb_key_debouncer;

   localparam int unsigned DC  = 4;
   localparam int unsigned DLY = 10;
   localparam int unsigned PER = 3;

   logic clock;
   logic reset;
   logic key_sync;
   logic a_level, a_press, a_release, a_event;
   logic b_level, b_press, b_release, b_event;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DC), .DAS_DELAY(DLY), .DAS_PERIOD(PER),
      .REPEAT_EN(1'b1), .PRESSED_LEVEL(1'b0)
   ) u_dut_rep (
      .clock(clock), .reset(reset), .key_sync(key_sync),
      .key_level(a_level), .press_pulse(a_press),
      .release_pulse(a_release), .key_event(a_event)
   );

   key_debouncer #(
      .DEBOUNCE_CYCLES(DC), .DAS_DELAY(DLY), .DAS_PERIOD(PER),
      .REPEAT_EN(1'b0), .PRESSED_LEVEL(1'b0)
   ) u_dut_norep (
      .clock(clock), .reset(reset), .key_sync(key_sync),
      .key_level(b_level), .press_pulse(b_press),
      .release_pulse(b_release), .key_event(b_event)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int          cyc      = 0;

   // Reference model: level flips once the last DC samples since reset all disagree;
   // repeats are derived from elapsed cycles since the accepted press.
   logic m_level   = 1'b0;
   logic m_press   = 1'b0;
   logic m_release = 1'b0;
   logic m_rep     = 1'b0;
   logic hist[$];
   int   t0        = 0;
   logic prev_a_event = 1'b0;
   logic prev_b_event = 1'b0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0b expected %0b at cycle %0d", tag, obs, exp, cyc);
   endtask

   task automatic model_step();
      logic raw;
      bit   all_dis;
      int   dt;
      cyc++;
      m_press   = 1'b0;
      m_release = 1'b0;
      m_rep     = 1'b0;
      if (reset) begin
         m_level = 1'b0;
         hist.delete();
      end else begin
         raw = (key_sync == 1'b0);
         hist.push_back(raw);
         if (hist.size() > DC) void'(hist.pop_front());
         all_dis = (hist.size() == DC);
         foreach (hist[i]) if (hist[i] == m_level) all_dis = 1'b0;
         if (all_dis) begin
            m_level = raw;
            if (raw) begin
               m_press = 1'b1;
               t0      = cyc;
            end else begin
               m_release = 1'b1;
            end
         end else if (m_level) begin
            dt = cyc - t0;
            if (dt == DLY || (dt > DLY && ((dt - DLY) % PER) == 0)) m_rep = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      chk("a_level",   a_level,   m_level);
      chk("a_press",   a_press,   m_press);
      chk("a_release", a_release, m_release);
      chk("a_event",   a_event,   m_press | m_rep);
      chk("b_level",   b_level,   m_level);
      chk("b_press",   b_press,   m_press);
      chk("b_release", b_release, m_release);
      chk("b_event",   b_event,   m_press);
      chk("a_press_and_release", a_press & a_release, 1'b0);
      chk("a_event_back_to_back", a_event & prev_a_event, 1'b0);
      chk("b_event_back_to_back", b_event & prev_b_event, 1'b0);
      prev_a_event = a_event;
      prev_b_event = b_event;
   endtask

   task automatic wait_press();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_press) break;
      end
      chk("wait_press", a_press, 1'b1);
   endtask

   initial begin
      reset    = 1'b1;
      key_sync = 1'b0;
      // Key held through reset: outputs stay low, press fires DC edges after release.
      repeat (5) tick();
      reset = 1'b0;
      repeat (8) tick();
      key_sync = 1'b1;
      repeat (8) tick();

      // Glitch of DC-1 samples is rejected, DC samples is accepted.
      key_sync = 1'b0; repeat (3) tick();
      key_sync = 1'b1; repeat (6) tick();
      key_sync = 1'b0; repeat (4) tick();
      chk("glitch4_level", a_level, 1'b1);
      key_sync = 1'b1; repeat (8) tick();

      // Long hold: repeat train, then release.
      key_sync = 1'b0; wait_press();
      repeat (30) tick();
      key_sync = 1'b1; repeat (8) tick();
      chk("after_release_level", a_level, 1'b0);

      // Release accepted exactly on a repeat terminal count (press + 16).
      key_sync = 1'b0; wait_press();
      repeat (12) tick();
      key_sync = 1'b1;
      repeat (4) tick();
      chk("rel_vs_rep_release", a_release, 1'b1);
      chk("rel_vs_rep_event",   a_event,   1'b0);
      repeat (6) tick();

      // Reset while in the repeat phase.
      key_sync = 1'b0; wait_press();
      repeat (15) tick();
      reset = 1'b1; tick();
      chk("midhold_reset_level",   a_level,   1'b0);
      chk("midhold_reset_release", a_release, 1'b0);
      chk("midhold_reset_event",   a_event,   1'b0);
      reset = 1'b0; repeat (8) tick();
      key_sync = 1'b1; repeat (8) tick();

      // Random bouncing, long holds and occasional resets.
      for (int s = 0; s < 200; s++) begin
         int unsigned len;
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 2)) tick();
            reset = 1'b0;
         end
         key_sync = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 5);
         repeat (len) tick();
      end
      key_sync = 1'b1;
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Debounces and conditions one already-synchronized push-button signal in the 50 MHz domain and turns it into game-ready events. It sits directly downstream of the two-flop synchronizer, consuming its `key_sync` output, and feeds the Tetris input/control logic. Outputs are a clean held level, a single-cycle press pulse, a release pulse, and an auto-repeat (delayed auto shift) event stream for held keys.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms @ 50 MHz): consecutive stable samples required to accept a level change; legal range ≥1.
- `DAS_DELAY`, default 10_000_000 (200 ms): cycles from accepted press to the first repeat; legal range ≥2.
- `DAS_PERIOD`, default 2_500_000 (50 ms): cycles between subsequent repeats; legal range ≥2.
- `REPEAT_EN`, default 1: 0 disables all repeat pulses.
- `PRESSED_LEVEL`, default 0: `key_sync` value meaning "pressed" (DE1 KEYs are active-low).
- Counter widths are `$clog2` of the respective parameter, minimum 1 bit.

Ports:
- `clock` in 1: 50 MHz system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `key_sync` in 1: synchronized raw button from the synchronizer.
- `key_level` out 1: debounced state, 1 = pressed.
- `press_pulse` out 1: one-cycle pulse on accepted press.
- `release_pulse` out 1: one-cycle pulse on accepted release.
- `key_event` out 1: `press_pulse` OR repeat pulse; the primary move strobe.

## Operation
- Normalized input `raw = (key_sync == PRESSED_LEVEL)`.
- Debounce counter `dcnt`:
  - On each edge with `raw == key_level`, `dcnt <= 0`.
  - With `raw != key_level` and `dcnt < DEBOUNCE_CYCLES-1`, `dcnt++`.
  - With `raw != key_level` and `dcnt == DEBOUNCE_CYCLES-1`, `key_level <= raw` and `dcnt <= 0`.
  - Any single agreeing sample restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` samples never propagate.
- Repeat FSM has three states, driven by accepted transitions only:
  - RELEASED: on accepted press, go to HOLD_DELAY, `tcnt <= 0`, assert `press_pulse`.
  - HOLD_DELAY: `tcnt++`. At `tcnt == DAS_DELAY-1`, emit a repeat pulse (only if `REPEAT_EN`), `tcnt <= 0`, go to HOLD_REPEAT.
  - HOLD_REPEAT: `tcnt++`. At `tcnt == DAS_PERIOD-1`, emit a repeat pulse, `tcnt <= 0`, stay in HOLD_REPEAT.
  - From HOLD_DELAY or HOLD_REPEAT, an accepted release goes to RELEASED, asserts `release_pulse` and sets `tcnt <= 0`. Release takes priority over a same-cycle repeat terminal count: no repeat pulse is emitted on that edge.
- `REPEAT_EN = 0`: the FSM still tracks held/released; the repeat pulse is forced to 0.
- `press_pulse` and `release_pulse` are never both high. `key_event` is never high two cycles in a row.
- All outputs are registered; there are no combinational paths from `key_sync`.

## Timing
- Reset values: `key_level = 0`, `press_pulse = 0`, `release_pulse = 0`, `key_event = 0`, FSM state RELEASED, `dcnt = 0`, `tcnt = 0`.
- Reset applies regardless of `key_sync`. A key held through reset is re-debounced after reset deasserts, so `press_pulse` fires `DEBOUNCE_CYCLES` edges later.
- Debounce latency: let edge k be the first edge sampling a changed `raw`. `key_level`, `press_pulse` or `release_pulse`, and `key_event` update after edge k+DEBOUNCE_CYCLES-1. With `DEBOUNCE_CYCLES = 1`, they follow on the same edge, one cycle behind `key_sync`.
- First repeat: `DAS_DELAY` cycles after `press_pulse`. Subsequent repeats: every `DAS_PERIOD` cycles.
- Reset mid-hold: all counters cleared and no pulse on the reset edge.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `DAS_DELAY=10`, `DAS_PERIOD=3`, `PRESSED_LEVEL=0`.
- Reset: hold `key_sync = 0` with `reset` high for 5 cycles → all outputs 0 throughout. Release `reset` → `press_pulse` high for exactly 1 cycle, 4 edges later.
- Glitch rejection: `key_sync` low for 3 cycles, then high → `key_level` stays 0 and no pulses occur. Repeat with a 4-cycle low → exactly one `press_pulse`, and `key_level = 1`.
- Auto-repeat: press and hold for 30 cycles after acceptance → `key_event` at offsets 0, 10, 13, 16, 19, 22, 25, 28, each exactly 1 cycle wide.
- Release: release after a 12-cycle hold (≥4 stable samples) → `release_pulse` 1 cycle, `key_level` back to 0, and no further `key_event`. Also time the release so it is accepted on the same edge as a repeat terminal count → no repeat pulse on that edge.
- `REPEAT_EN=0`: hold for 30 cycles → a single `key_event` (the press) only.
- Reset mid-hold: assert `reset` in HOLD_REPEAT → outputs 0 the next cycle, with no spurious `release_pulse`.
